mem_port_arbiter: RTL

- Shares one single-ported data/instruction memory between the IF-stage fetch port and the ME-stage load/store port.
- Grants one requester at a time and sequences a fixed-latency access.
- Returns a one-cycle ack with registered read data.
- Generates per-port stall levels consumed by the pipeline stall controller.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/arb_wait_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner codes,
// access width codes and the wait/starve counter width.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam logic [1:0] WL_BYTE = 2'd0;
    localparam logic [1:0] WL_HALF = 2'd1;
    localparam logic [1:0] WL_WORD = 2'd2;

    localparam int CNT_W = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Access latency down-counter: loaded at grant, decremented while the
// access is in flight, flags the final cycle (count == 1).
module arb_wait_counter
    import arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between fetch and load/store ports with
// fixed-latency sequencing. Optional fetch abort on branch flush: ARB_FLUSH_EN.
//
// state | meaning
// IDLE  | no access; grant the winning requester at the next edge
// BUSY  | memory access in flight, mem_* held, counter running
// ACK   | one-cycle completion pulse, requests ignored
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int MEM_LAT          = 2,
    parameter int FETCH_STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
`ifdef ARB_FLUSH_EN
    input  logic        if_flush,
`endif
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_wl,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        if_stall,
    output logic        d_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_wl,
    input  logic [31:0] mem_rdata,
    output logic        owner
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(FETCH_STARVE_MAX);
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT);

    arb_state_t       state, next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;
    logic             grant_if, grant_d, finish, abort;
    logic             cnt_last;
    logic             flush;

`ifdef ARB_FLUSH_EN
    assign flush = if_flush;
`else
    assign flush = 1'b0;
`endif

    assign starve_hit = (starve_cnt == STARVE_MAX);

    arb_wait_counter u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (grant_if | grant_d),
        .load_val (LAT_LOAD),
        .dec      (state == BUSY),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                // A flushed fetch is never eligible, so data may win even at the starve limit
                grant_if = if_req & ~flush & (~d_req | starve_hit);
                grant_d  = d_req & ~grant_if;
                if (grant_if || grant_d) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (owner == OWN_IF && flush) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (cnt_last) begin
                    finish     = 1'b1;
                    next_state = ACK;
                end
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wl     <= WL_BYTE;
            owner      <= OWN_IF;
            starve_cnt <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_ack <= finish & (owner == OWN_IF);
            d_ack  <= finish & (owner == OWN_D);
            if (grant_d) begin
                mem_en    <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wl    <= d_wl;
                owner     <= OWN_D;
                if (!if_req) begin
                    starve_cnt <= '0;
                end else if (!starve_hit) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (grant_if) begin
                mem_en     <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
                mem_wl     <= WL_WORD;
                owner      <= OWN_IF;
                starve_cnt <= '0;
            end else if (finish || abort) begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end
            if (finish && owner == OWN_IF) begin
                if_rdata <= mem_rdata;
            end
            if (finish && owner == OWN_D && !mem_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    // Stalls read as 0 while held in reset, matching the other outputs
    assign if_stall = rst_n & if_req & ~if_ack;
    assign d_stall  = rst_n & d_req & ~d_ack;

endmodule
